// File: rtl/dmem_dump_engine_pkg.sv
// Shared definitions for the DMEM dump engine: FSM state encodings, the
// default ebreak encoding and the address tag of the optional checksum beat.
package dmem_dump_engine_pkg;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_DRAIN,
    ST_READ,
    ST_CAPTURE,
    ST_EMIT,
    ST_CKSUM,   // load the checksum beat (DUMP_CHECKSUM_EN builds only)
    ST_CKEMIT,  // hold the checksum beat until accepted
    ST_DONE
  } state_e;

  localparam logic [31:0] EBREAK_WORD_DEF = 32'h0010_0073;
  localparam logic [31:0] CHECKSUM_ADDR   = 32'hFFFF_FFFC;
  localparam logic [31:0] CYC_SAT         = 32'hFFFF_FFFF;

  // DMEM word index -> byte address
  function automatic logic [31:0] word_to_byte(input logic [31:0] idx);
    return idx << 2;
  endfunction

endpackage

// File: rtl/dump_beat_reg.sv
// Output beat holding register: a load captures addr/data and raises valid,
// valid drops on the valid&&ready handshake. addr/data never move while valid.
module dump_beat_reg (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [31:0] addr_o,
  output logic [31:0] data_o
);

  logic        valid_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;

  // load has priority; a load is only issued while no beat is pending
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      addr_q  <= addr_i;
      data_q  <= data_i;
    end else if (valid_q && ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign addr_o  = addr_q;
  assign data_o  = data_q;

endmodule

// File: rtl/dmem_dump_engine.sv
// End-of-program DMEM dump engine. Watches the fetched instruction for ebreak
// (or a run-cycle timeout), drains the pipeline, halts the core and streams
// DMEM words 0..DUMP_WORDS-1 as (byte address, data) beats.
// Optional feature macro: DUMP_CHECKSUM_EN appends a mod-2^32 sum beat.
module dmem_dump_engine
  import dmem_dump_engine_pkg::*;
#(
  parameter int unsigned DUMP_WORDS     = 20,
  parameter int unsigned DMEM_ADDR_W    = 9,
  parameter int unsigned DRAIN_CYCLES   = 5,
  parameter int unsigned TIMEOUT_CYCLES = 20000,
  parameter logic [31:0] EBREAK_WORD    = EBREAK_WORD_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            inst_from_imem,
  output logic                   cpu_halt,
  output logic                   dmem_rd_en,
  output logic [DMEM_ADDR_W-1:0] dmem_rd_addr,
  input  logic [31:0]            dmem_rd_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_addr,
  output logic [31:0]            out_data,
  output logic [31:0]            cycle_count,
  output logic                   timed_out,
  output logic                   done
);

  localparam int unsigned DRW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DRW-1:0]         DRAIN_LAST = DRW'(DRAIN_CYCLES - 1);
  localparam logic [DMEM_ADDR_W-1:0] LAST_IDX   = DMEM_ADDR_W'(DUMP_WORDS - 1);
  localparam logic [31:0]            TO_LAST    = 32'(TIMEOUT_CYCLES - 1);

  state_e                 state_q;
  logic [DRW-1:0]         drn_q;
  logic [DMEM_ADDR_W-1:0] idx_q;
  logic                   halt_q, rd_en_q, to_q, done_q;
  logic [DMEM_ADDR_W-1:0] rd_addr_q;
  logic [31:0]            cyc_q;
`ifdef DUMP_CHECKSUM_EN
  logic [31:0]            sum_q;
`endif

  logic        beat_load_d;
  logic [31:0] beat_addr_d, beat_data_d;
  logic        hs;

  assign hs = out_valid && out_ready;

  // beat register load: a DMEM word in CAPTURE, the running sum in CKSUM
  always_comb begin
    beat_load_d = (state_q == ST_CAPTURE);
    beat_addr_d = word_to_byte(32'(idx_q));
    beat_data_d = dmem_rd_data;
`ifdef DUMP_CHECKSUM_EN
    if (state_q == ST_CKSUM) begin
      beat_load_d = 1'b1;
      beat_addr_d = CHECKSUM_ADDR;
      beat_data_d = sum_q;
    end
`endif
  end

  // control FSM; all core/DMEM-facing outputs are registered here
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_RUN;
      drn_q     <= '0;
      idx_q     <= '0;
      halt_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      cyc_q     <= '0;
      to_q      <= 1'b0;
      done_q    <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      sum_q     <= '0;
`endif
    end else begin
      rd_en_q <= 1'b0;
      case (state_q)
        ST_RUN: begin
          // ebreak wins over a coincident timeout; count freezes on exit
          if (inst_from_imem == EBREAK_WORD) begin
            state_q <= ST_DRAIN;
            drn_q   <= '0;
          end else if (cyc_q == TO_LAST) begin
            state_q <= ST_DRAIN;
            drn_q   <= '0;
            to_q    <= 1'b1;
          end else if (cyc_q != CYC_SAT) begin
            cyc_q <= cyc_q + 32'd1;
          end
        end
        ST_DRAIN: begin
          if (drn_q == DRAIN_LAST) begin
            state_q   <= ST_READ;
            halt_q    <= 1'b1;
            rd_en_q   <= 1'b1;
            rd_addr_q <= idx_q;
          end else begin
            drn_q <= drn_q + 1'b1;
          end
        end
        ST_READ:    state_q <= ST_CAPTURE;
        ST_CAPTURE: begin
          state_q <= ST_EMIT;
`ifdef DUMP_CHECKSUM_EN
          sum_q   <= sum_q + dmem_rd_data;
`endif
        end
        ST_EMIT: begin
          if (hs) begin
            if (idx_q == LAST_IDX) begin
`ifdef DUMP_CHECKSUM_EN
              state_q <= ST_CKSUM;
`else
              state_q <= ST_DONE;
              done_q  <= 1'b1;
`endif
            end else begin
              idx_q     <= idx_q + 1'b1;
              state_q   <= ST_READ;
              rd_en_q   <= 1'b1;
              rd_addr_q <= idx_q + 1'b1;
            end
          end
        end
`ifdef DUMP_CHECKSUM_EN
        ST_CKSUM:  state_q <= ST_CKEMIT;
        ST_CKEMIT: begin
          if (hs) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
`endif
        ST_DONE: state_q <= ST_DONE;
        default: state_q <= ST_RUN;
      endcase
    end
  end

  dump_beat_reg u_beat (
    .clk     (clk),
    .reset   (reset),
    .load_i  (beat_load_d),
    .addr_i  (beat_addr_d),
    .data_i  (beat_data_d),
    .ready_i (out_ready),
    .valid_o (out_valid),
    .addr_o  (out_addr),
    .data_o  (out_data)
  );

  assign cpu_halt     = halt_q;
  assign dmem_rd_en   = rd_en_q;
  assign dmem_rd_addr = rd_addr_q;
  assign cycle_count  = cyc_q;
  assign timed_out    = to_q;
  assign done         = done_q;

endmodule

// File: tb/tb_dmem_dump_engine.sv
// Bench for dmem_dump_engine: DMEM model, randomized ready/back-pressure and
// a reference dump list built directly from the memory contents.
module tb_dmem_dump_engine;

  localparam int DW = 20;
  localparam int DR = 5;
  localparam int TO = 20000;
  localparam logic [31:0] EBRK = 32'h0010_0073;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] inst_from_imem = NOP;
  logic        cpu_halt, dmem_rd_en, out_valid, timed_out, done;
  logic [8:0]  dmem_rd_addr;
  logic [31:0] dmem_rd_data = '0;
  logic        out_ready = 1'b0;
  logic [31:0] out_addr, out_data, cycle_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rdy_mode = 0;  // 0 always, 1 one-of-three, 2 random, 3 never

  logic [31:0] mem [0:511];
  logic [31:0] got_a[$], got_d[$], exp_a[$], exp_d[$];
  logic        hold_pend = 1'b0;
  logic [31:0] hold_a, hold_d;

  dmem_dump_engine dut (
    .clk            (clk),
    .reset          (reset),
    .inst_from_imem (inst_from_imem),
    .cpu_halt       (cpu_halt),
    .dmem_rd_en     (dmem_rd_en),
    .dmem_rd_addr   (dmem_rd_addr),
    .dmem_rd_data   (dmem_rd_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_addr       (out_addr),
    .out_data       (out_data),
    .cycle_count    (cycle_count),
    .timed_out      (timed_out),
    .done           (done)
  );

  always #5 clk = ~clk;

  // synchronous-read DMEM, one cycle latency
  always @(posedge clk) if (dmem_rd_en) dmem_rd_data <= mem[dmem_rd_addr];

  // consumer: choose ready, record accepted beats, check held beats stay put
  always @(negedge clk) begin
    cyc++;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = (cyc % 3 == 0);
      2:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
    if (reset && hold_pend) begin
      total++;
      if (!(out_valid === 1'b1 && out_addr === hold_a && out_data === hold_d)) begin
        bad++;
        $display("FAIL hold_stable got v=%b %h/%h exp v=1 %h/%h", out_valid, out_addr, out_data, hold_a, hold_d);
      end
    end
    hold_pend = reset && out_valid && !out_ready;
    hold_a = out_addr;
    hold_d = out_data;
    if (reset && out_valid && out_ready) begin
      got_a.push_back(out_addr);
      got_d.push_back(out_data);
    end
  end

  // reference dump: word i at byte 4*i, plus the optional sum beat
  task automatic build_expected();
    logic [31:0] s = '0;
    exp_a.delete(); exp_d.delete();
    for (int i = 0; i < DW; i++) begin
      exp_a.push_back(32'(i * 4));
      exp_d.push_back(mem[i]);
      s += mem[i];
    end
`ifdef DUMP_CHECKSUM_EN
    exp_a.push_back(32'hFFFF_FFFC);
    exp_d.push_back(s);
`endif
  endtask

  task automatic do_reset();
    @(posedge clk); #2 reset = 1'b0;
    @(posedge clk); #2 reset = 1'b1;
    got_a.delete(); got_d.delete();
  endtask

  // ebreak is sampled while cycle_count == n
  task automatic run_prog(input int n);
    repeat (n) @(posedge clk);
    #2 inst_from_imem = EBRK;
    @(posedge clk); #2 inst_from_imem = NOP;
  endtask

  task automatic wait_done(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim && !ok; i++) begin
      @(negedge clk);
      ok = done;
    end
  endtask

  task automatic test_reset();
    inst_from_imem = NOP;
    do_reset();
    @(negedge clk);
    total++;
    if ({cpu_halt, dmem_rd_en, dmem_rd_addr, out_valid, timed_out, done} !== '0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b exp=0", {cpu_halt, dmem_rd_en, dmem_rd_addr, out_valid, timed_out, done});
    end
    total++;
    if ({out_addr, out_data} !== '0) begin
      bad++; $display("FAIL reset_beat got=%h/%h exp=0/0", out_addr, out_data);
    end
    total++;
    if (cycle_count !== 32'd0) begin
      bad++; $display("FAIL reset_count got=%0d exp=0", cycle_count);
    end
  endtask

  task automatic test_basic();
    bit ok;
    for (int i = 0; i < 512; i++) mem[i] = 32'(i * 16 + 1);
    build_expected();
    rdy_mode = 0;
    do_reset();
    run_prog(40);
    wait_done(300, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL basic_done got=0 exp=1"); end
    total++;
    if (cycle_count !== 32'd40 || timed_out !== 1'b0) begin
      bad++; $display("FAIL basic_count got=%0d/%b exp=40/0", cycle_count, timed_out);
    end
    total++;
    if (cpu_halt !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL basic_final got halt=%b v=%b exp halt=1 v=0", cpu_halt, out_valid);
    end
    total++;
    if (got_a.size() != exp_a.size()) begin
      bad++; $display("FAIL basic_nbeats got=%0d exp=%0d", got_a.size(), exp_a.size());
    end else for (int i = 0; i < exp_a.size(); i++) begin
      total++;
      if (got_a[i] !== exp_a[i] || got_d[i] !== exp_d[i]) begin
        bad++; $display("FAIL basic_beat%0d got=%h/%h exp=%h/%h", i, got_a[i], got_d[i], exp_a[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int n = $urandom_range(1, 30);
    for (int i = 0; i < 512; i++) mem[i] = $urandom;
    build_expected();
    rdy_mode = 1;
    do_reset();
    run_prog(n);
    wait_done(800, ok);
    total++;
    if (!ok || cycle_count !== 32'(n)) begin
      bad++; $display("FAIL bp_done got=%b/%0d exp=1/%0d", ok, cycle_count, n);
    end
    total++;
    if (got_a.size() != exp_a.size()) begin
      bad++; $display("FAIL bp_nbeats got=%0d exp=%0d", got_a.size(), exp_a.size());
    end else for (int i = 0; i < exp_a.size(); i++) begin
      total++;
      if (got_a[i] !== exp_a[i] || got_d[i] !== exp_d[i]) begin
        bad++; $display("FAIL bp_beat%0d got=%h/%h exp=%h/%h", i, got_a[i], got_d[i], exp_a[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_timeout();
    bit ok;
    logic [31:0] w = $urandom;
    if (w == EBRK) w ^= 32'h1;
    for (int i = 0; i < 512; i++) mem[i] = $urandom;
    build_expected();
    rdy_mode = 2;
    inst_from_imem = w;
    do_reset();
    wait_done(TO + 2000, ok);
    inst_from_imem = NOP;
    total++;
    if (!ok || timed_out !== 1'b1 || cycle_count !== 32'(TO - 1)) begin
      bad++; $display("FAIL timeout got=%b/%b/%0d exp=1/1/%0d", ok, timed_out, cycle_count, TO - 1);
    end
    total++;
    if (got_a.size() != exp_a.size()) begin
      bad++; $display("FAIL to_nbeats got=%0d exp=%0d", got_a.size(), exp_a.size());
    end else for (int i = 0; i < exp_a.size(); i++) begin
      total++;
      if (got_a[i] !== exp_a[i] || got_d[i] !== exp_d[i]) begin
        bad++; $display("FAIL to_beat%0d got=%h/%h exp=%h/%h", i, got_a[i], got_d[i], exp_a[i], exp_d[i]);
      end
    end
  endtask

  // ebreak in the very cycle the timeout fires: ebreak takes precedence
  task automatic test_ebreak_at_timeout();
    bit ok;
    build_expected();
    rdy_mode = 0;
    do_reset();
    run_prog(TO - 1);
    wait_done(400, ok);
    total++;
    if (!ok || timed_out !== 1'b0 || cycle_count !== 32'(TO - 1)) begin
      bad++; $display("FAIL ebrk_at_to got=%b/%b/%0d exp=1/0/%0d", ok, timed_out, cycle_count, TO - 1);
    end
    total++;
    if (got_a.size() != exp_a.size()) begin
      bad++; $display("FAIL ebrk_at_to_nbeats got=%0d exp=%0d", got_a.size(), exp_a.size());
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n;
    for (int i = 0; i < 512; i++) mem[i] = $urandom;
    build_expected();
    rdy_mode = 2;
    do_reset();
    run_prog($urandom_range(1, 20));
    for (int i = 0; i < 2000 && got_a.size() < 7; i++) @(posedge clk);
    #1 rdy_mode = 3;
    for (int i = 0; i < 20 && !out_valid; i++) begin @(posedge clk); #1; end
    total++;
    if (out_valid !== 1'b1 || out_addr !== 32'h1C) begin
      bad++; $display("FAIL rmid_pre got=%b/%h exp=1/0000001c", out_valid, out_addr);
    end
    #1 reset = 1'b0;
    @(posedge clk); @(negedge clk);
    total++;
    if ({cpu_halt, dmem_rd_en, dmem_rd_addr, out_valid, out_addr, out_data, cycle_count, timed_out, done} !== '0) begin
      bad++; $display("FAIL rmid_zero got halt=%b rd=%b v=%b a=%h d=%h c=%0d done=%b exp all 0",
                      cpu_halt, dmem_rd_en, out_valid, out_addr, out_data, cycle_count, done);
    end
    #1 reset = 1'b1;
    got_a.delete(); got_d.delete();
    rdy_mode = 2;
    n = $urandom_range(1, 20);
    run_prog(n);
    wait_done(1500, ok);
    total++;
    if (!ok || cycle_count !== 32'(n)) begin
      bad++; $display("FAIL rmid_done got=%b/%0d exp=1/%0d", ok, cycle_count, n);
    end
    total++;
    if (got_a.size() != exp_a.size()) begin
      bad++; $display("FAIL rmid_nbeats got=%0d exp=%0d", got_a.size(), exp_a.size());
    end else for (int i = 0; i < exp_a.size(); i++) begin
      total++;
      if (got_a[i] !== exp_a[i] || got_d[i] !== exp_d[i]) begin
        bad++; $display("FAIL rmid_beat%0d got=%h/%h exp=%h/%h", i, got_a[i], got_d[i], exp_a[i], exp_d[i]);
      end
    end
  endtask

  // ebreak stays on the fetch bus through drain/read: one dump, fixed latency
  task automatic test_ebreak_repeat();
    bit ok;
    int n = $urandom_range(3, 30);
    int k = 0, halt_k = 0, valid_k = 0;
    for (int i = 0; i < 512; i++) mem[i] = $urandom;
    build_expected();
    rdy_mode = 0;
    do_reset();
    repeat (n) @(posedge clk);
    #2 inst_from_imem = EBRK;
    while (valid_k == 0 && k < 50) begin
      @(posedge clk); #2 k++;
      if (cpu_halt === 1'b1 && halt_k == 0) halt_k = k;
      if (out_valid === 1'b1) valid_k = k;
    end
    wait_done(300, ok);
    inst_from_imem = NOP;
    total++;
    if (halt_k != DR + 1) begin bad++; $display("FAIL rep_halt_lat got=%0d exp=%0d", halt_k, DR + 1); end
    total++;
    if (valid_k != DR + 3) begin bad++; $display("FAIL rep_valid_lat got=%0d exp=%0d", valid_k, DR + 3); end
    total++;
    if (!ok || cycle_count !== 32'(n)) begin
      bad++; $display("FAIL rep_done got=%b/%0d exp=1/%0d", ok, cycle_count, n);
    end
    total++;
    if (got_a.size() != exp_a.size()) begin
      bad++; $display("FAIL rep_nbeats got=%0d exp=%0d", got_a.size(), exp_a.size());
    end else for (int i = 0; i < exp_a.size(); i++) begin
      total++;
      if (got_a[i] !== exp_a[i] || got_d[i] !== exp_d[i]) begin
        bad++; $display("FAIL rep_beat%0d got=%h/%h exp=%h/%h", i, got_a[i], got_d[i], exp_a[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_checksum();
    bit ok;
    for (int i = 0; i < 512; i++) mem[i] = 32'hFFFF_FFFF;
    build_expected();
    rdy_mode = 2;
    do_reset();
    run_prog(7);
    wait_done(1500, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL ck_done got=0 exp=1"); end
    total++;
    if (got_a.size() != exp_a.size()) begin
      bad++; $display("FAIL ck_nbeats got=%0d exp=%0d", got_a.size(), exp_a.size());
    end else begin
      for (int i = 0; i < exp_a.size(); i++) begin
        total++;
        if (got_a[i] !== exp_a[i] || got_d[i] !== exp_d[i]) begin
          bad++; $display("FAIL ck_beat%0d got=%h/%h exp=%h/%h", i, got_a[i], got_d[i], exp_a[i], exp_d[i]);
        end
      end
`ifdef DUMP_CHECKSUM_EN
      total++;
      if (got_a[DW] !== 32'hFFFF_FFFC || got_d[DW] !== 32'hFFFF_FFEC) begin
        bad++; $display("FAIL ck_sum got=%h/%h exp=fffffffc/ffffffec", got_a[DW], got_d[DW]);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_reset_mid();
    test_ebreak_repeat();
    test_checksum();
    test_timeout();
    test_ebreak_at_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
